// File: rtl/linear_layer_start_fifo_ctrl.sv
// Start-token FIFO between the Linear_Layer dispatcher and a PE: SRL storage, occupancy and HLS-style handshakes.
// Define LINEAR_START_FIFO_ERR_EN to build the sticky overflow/underflow flags; otherwise they are tied low.
module linear_layer_start_fifo_ctrl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   usedw,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] srl [DEPTH];
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH:0]   usedw_next;
  logic [ADDR_WIDTH-1:0] raddr;

  assign push = if_write & if_write_ce & if_full_n;
  assign pop  = if_read  & if_read_ce  & if_empty_n;

  // Storage is deliberately unreset; index 0 always holds the newest token.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        srl[i] <= srl[i-1];
      end
      srl[0] <= if_din;
    end
  end

  always_comb begin
    raddr = '0;
    if (usedw != '0) begin
      raddr = ADDR_WIDTH'(usedw - 1'b1);
    end
  end

  assign if_dout = srl[raddr];

  always_comb begin
    usedw_next = usedw;
    case ({push, pop})
      2'b10:   usedw_next = usedw + 1'b1;
      2'b01:   usedw_next = usedw - 1'b1;
      default: usedw_next = usedw;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      usedw      <= '0;
      if_full_n  <= 1'b1;
      if_empty_n <= 1'b0;
    end else begin
      usedw      <= usedw_next;
      if_full_n  <= (usedw_next != DEPTH_W);
      if_empty_n <= (usedw_next != '0);
    end
  end

`ifdef LINEAR_START_FIFO_ERR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (if_write & if_write_ce & !if_full_n) overflow_err  <= 1'b1;
      if (if_read  & if_read_ce  & !if_empty_n) underflow_err <= 1'b1;
    end
  end
`else
  assign overflow_err  = 1'b0;
  assign underflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_linear_layer_start_fifo_ctrl.sv
// Directed self-checking bench for linear_layer_start_fifo_ctrl at DEPTH=3, DATA_WIDTH=1, ADDR_WIDTH=2.
module tb_linear_layer_start_fifo_ctrl;

`ifdef LINEAR_START_FIFO_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       if_write_ce = 1'b1;
  logic       if_write = 1'b0;
  logic [0:0] if_din = 1'b0;
  logic       if_full_n;
  logic       if_read_ce = 1'b1;
  logic       if_read = 1'b0;
  logic [0:0] if_dout;
  logic       if_empty_n;
  logic [2:0] usedw;
  logic       overflow_err;
  logic       underflow_err;

  int tests = 0;
  int fails = 0;

  linear_layer_start_fifo_ctrl #(.DATA_WIDTH(1), .ADDR_WIDTH(2), .DEPTH(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din), .if_full_n(if_full_n),
    .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout), .if_empty_n(if_empty_n),
    .usedw(usedw), .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    if_write = 0; if_read = 0; if_write_ce = 1; if_read_ce = 1;
    reset_n = 0;
    step();
    reset_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    tests++; if ({if_full_n, if_empty_n, usedw, overflow_err, underflow_err} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL reset_idle got full_n=%b empty_n=%b usedw=%0d ovf=%b unf=%b exp 1 0 0 0 0",
                        if_full_n, if_empty_n, usedw, overflow_err, underflow_err);
    end
  endtask

  task automatic test_push_fill();
    logic [0:0] d [3];
    d[0] = 1; d[1] = 0; d[2] = 1;
    do_reset();
    // First edge after release must already accept the push.
    for (int i = 0; i < 3; i++) begin
      if_write = 1; if_din = d[i];
      step();
      tests++; if (usedw !== 3'(i + 1)) begin fails++; $display("FAIL fill_usedw got %0d exp %0d", usedw, i + 1); end
      tests++; if (if_dout !== 1'b1) begin fails++; $display("FAIL fill_dout got %0d exp 1", if_dout); end
      tests++; if (if_empty_n !== 1'b1) begin fails++; $display("FAIL fill_empty_n got %0d exp 1", if_empty_n); end
      tests++; if (if_full_n !== (i != 2)) begin fails++; $display("FAIL fill_full_n got %0d exp %0d", if_full_n, i != 2); end
    end
    if_write = 0;
    step();
    tests++; if (usedw !== 3'd3) begin fails++; $display("FAIL fill_hold got %0d exp 3", usedw); end
  endtask

  task automatic test_pop_drain();
    logic [0:0] e [3];
    e[0] = 1; e[1] = 0; e[2] = 1;
    for (int i = 0; i < 3; i++) begin
      tests++; if (if_dout !== e[i]) begin fails++; $display("FAIL drain_dout[%0d] got %0d exp %0d", i, if_dout, e[i]); end
      if_read = 1;
      step();
      tests++; if (usedw !== 3'(2 - i)) begin fails++; $display("FAIL drain_usedw got %0d exp %0d", usedw, 2 - i); end
      tests++; if (if_full_n !== 1'b1) begin fails++; $display("FAIL drain_full_n got %0d exp 1", if_full_n); end
      tests++; if (if_empty_n !== (i != 2)) begin fails++; $display("FAIL drain_empty_n got %0d exp %0d", if_empty_n, i != 2); end
    end
    if_read = 0;
  endtask

  task automatic test_simul();
    logic [0:0] din [4];
    logic [0:0] exp [4];
    din[0] = 1; din[1] = 0; din[2] = 0; din[3] = 1;
    exp[0] = 0; exp[1] = 1; exp[2] = 0; exp[3] = 0;
    do_reset();
    if_write = 1; if_din = 0;
    step();
    for (int i = 0; i < 4; i++) begin
      if_write = 1; if_read = 1; if_din = din[i];
      tests++; if (if_dout !== exp[i]) begin fails++; $display("FAIL simul_pop[%0d] got %0d exp %0d", i, if_dout, exp[i]); end
      step();
      tests++; if (usedw !== 3'd1) begin fails++; $display("FAIL simul_usedw got %0d exp 1", usedw); end
    end
    if_write = 0; if_read = 0;
    tests++; if (if_dout !== 1'b1) begin fails++; $display("FAIL simul_last got %0d exp 1", if_dout); end
  endtask

  task automatic test_boundary();
    do_reset();
    if_write = 1;
    if_din = 0; step();
    if_din = 1; step();
    if_din = 1; step();
    if_read = 1; if_din = 0;
    step();
    tests++; if (usedw !== 3'd2) begin fails++; $display("FAIL full_wr_rd_usedw got %0d exp 2", usedw); end
    tests++; if (if_dout !== 1'b1) begin fails++; $display("FAIL full_wr_rd_dout got %0d exp 1", if_dout); end
    tests++; if (if_full_n !== 1'b1) begin fails++; $display("FAIL full_wr_rd_full_n got %0d exp 1", if_full_n); end
    tests++; if (overflow_err !== ERR) begin fails++; $display("FAIL full_wr_rd_ovf got %0d exp %0d", overflow_err, ERR); end
    if_write = 0;
    step(); step();
    tests++; if (if_empty_n !== 1'b0) begin fails++; $display("FAIL drain_to_empty got %0d exp 0", if_empty_n); end
    if_write = 1; if_read = 1; if_din = 1;
    step();
    tests++; if (usedw !== 3'd1) begin fails++; $display("FAIL empty_wr_rd_usedw got %0d exp 1", usedw); end
    tests++; if (if_dout !== 1'b1) begin fails++; $display("FAIL empty_wr_rd_dout got %0d exp 1", if_dout); end
    if_read = 0; if_write_ce = 0; if_din = 0;
    step(); step();
    tests++; if (usedw !== 3'd1 || if_dout !== 1'b1) begin
      fails++; $display("FAIL write_ce_low got usedw=%0d dout=%0d exp 1 1", usedw, if_dout);
    end
    if_write = 0; if_write_ce = 1;
  endtask

  task automatic test_errors();
    do_reset();
    if_read = 1; if_read_ce = 0; if_write = 1; if_write_ce = 0;
    step();
    tests++; if (underflow_err !== 1'b0 || overflow_err !== 1'b0 || usedw !== 3'd0) begin
      fails++; $display("FAIL ce_low_no_err got unf=%0d ovf=%0d usedw=%0d exp 0 0 0", underflow_err, overflow_err, usedw);
    end
    if_read = 0; if_read_ce = 1; if_write_ce = 1;
    step(); step(); step();
    tests++; if (overflow_err !== 1'b0) begin fails++; $display("FAIL ovf_before got %0d exp 0", overflow_err); end
    step();
    if_write = 0;
    tests++; if (overflow_err !== ERR || usedw !== 3'd3) begin
      fails++; $display("FAIL ovf_set got ovf=%0d usedw=%0d exp %0d 3", overflow_err, usedw, ERR);
    end
    if_read = 1;
    step(); step(); step();
    if_read = 0;
    tests++; if (overflow_err !== ERR || underflow_err !== 1'b0) begin
      fails++; $display("FAIL ovf_held got ovf=%0d unf=%0d exp %0d 0", overflow_err, underflow_err, ERR);
    end
    if_read = 1;
    step();
    if_read = 0;
    tests++; if (underflow_err !== ERR) begin fails++; $display("FAIL unf_set got %0d exp %0d", underflow_err, ERR); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    if_write = 1; if_din = 1;
    step(); step();
    if_write = 0;
    tests++; if (usedw !== 3'd2) begin fails++; $display("FAIL mid_pre got %0d exp 2", usedw); end
    #2 reset_n = 0;
    #1;
    tests++; if ({if_full_n, if_empty_n, usedw, overflow_err, underflow_err} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL mid_reset got full_n=%b empty_n=%b usedw=%0d ovf=%b unf=%b exp 1 0 0 0 0",
                        if_full_n, if_empty_n, usedw, overflow_err, underflow_err);
    end
    #3 reset_n = 1;
    if_write = 1; if_din = 0;
    step();
    if_write = 0;
    tests++; if (usedw !== 3'd1 || if_dout !== 1'b0) begin
      fails++; $display("FAIL post_reset_push got usedw=%0d dout=%0d exp 1 0", usedw, if_dout);
    end
  endtask

  initial begin
    test_reset();
    test_push_fill();
    test_pop_drain();
    test_simul();
    test_boundary();
    test_errors();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
